// File: rtl/t09_tone_player.sv
// t09_tone_player: latches a tone code and plays a fixed-length square-wave note; held codes do not retrigger.
// Optional done_o note-end pulse enabled by defining T09_TONE_DONE_PULSE_EN.
module t09_tone_player #(
  parameter int PRESCALE  = 256,
  parameter int DUR_TICKS = 9375
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] freq_i,
  output logic       square_o,
  output logic       playing_o
`ifdef T09_TONE_DONE_PULSE_EN
  ,
  output logic       done_o
`endif
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, HOLD = 2'd2;
  logic [1:0] state;
  logic [7:0] code_q, half_cnt;
  logic [PW-1:0] pre_cnt;
  logic [15:0] dur_cnt;
  logic tick, start, half_end;
  assign tick = pre_cnt == PW'(PRESCALE - 1);
  // From IDLE any nonzero code starts; elsewhere only a different code retriggers.
  assign start = freq_i != 8'd0 && (state == IDLE || freq_i != code_q);
  assign half_end = half_cnt == code_q - 8'd1;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      code_q    <= '0;
      half_cnt  <= '0;
      pre_cnt   <= '0;
      dur_cnt   <= '0;
      square_o  <= 1'b0;
      playing_o <= 1'b0;
`ifdef T09_TONE_DONE_PULSE_EN
      done_o    <= 1'b0;
`endif
    end else begin
`ifdef T09_TONE_DONE_PULSE_EN
      done_o <= 1'b0;
`endif
      if (start) begin
        state     <= PLAY;
        playing_o <= 1'b1;
        code_q    <= freq_i;
        pre_cnt   <= '0;
        half_cnt  <= '0;
        dur_cnt   <= 16'(DUR_TICKS);
        square_o  <= 1'b0;
      end else if (state == PLAY) begin
        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        if (tick && dur_cnt == 16'd1) begin
          state     <= HOLD;
          playing_o <= 1'b0;
          square_o  <= 1'b0;
          pre_cnt   <= '0;
          half_cnt  <= '0;
          dur_cnt   <= '0;
`ifdef T09_TONE_DONE_PULSE_EN
          done_o    <= 1'b1;
`endif
        end else if (tick) begin
          dur_cnt  <= dur_cnt - 16'd1;
          half_cnt <= half_end ? '0 : half_cnt + 8'd1;
          square_o <= square_o ^ half_end;
        end
      end else if (state == HOLD && freq_i == 8'd0) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_t09_tone_player.sv
// tb_t09_tone_player: table-driven scenarios with a queue scoreboard, PRESCALE=4, DUR_TICKS=8.
module tb_t09_tone_player;
  logic clk = 1'b0, nrst = 1'b0;
  logic [7:0] freq_i = '0;
  logic square_o, playing_o;
  logic done_w;
  int checks = 0, errors = 0;
  typedef struct {int cyc; logic [7:0] f; logic sq; logic pl; logic dn;} vec_t;
  typedef struct {string name; int cyc; logic sq; logic pl; logic dn;} exp_t;
  exp_t sb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  t09_tone_player #(.PRESCALE(4), .DUR_TICKS(8)) dut (
    .clk(clk), .nrst(nrst), .freq_i(freq_i), .square_o(square_o), .playing_o(playing_o)
`ifdef T09_TONE_DONE_PULSE_EN
    , .done_o(done_w)
`endif
  );
`ifndef T09_TONE_DONE_PULSE_EN
  assign done_w = 1'b0;
`endif

  task automatic chk(input string name, input int cyc, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, got, exp);
    end
  endtask

  task automatic do_reset();
    freq_i = '0;
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  // Cycle c drives freq before edge c and checks outputs just after edge c.
  task automatic run(input string name, input int len);
    int idx = 0;
    logic [7:0] cur = '0;
    exp_t e;
    do_reset();
    for (int c = 0; c < len; c++) begin
      bit hit = 0;
      if (idx < tbl.size() && tbl[idx].cyc == c) begin
        cur = tbl[idx].f;
        sb.push_back('{name, c, tbl[idx].sq, tbl[idx].pl, tbl[idx].dn});
        hit = 1;
        idx++;
      end
      freq_i = cur;
      @(posedge clk);
      #1;
      if (hit) begin
        e = sb.pop_front();
        chk({e.name, " square"}, e.cyc, square_o, e.sq);
        chk({e.name, " playing"}, e.cyc, playing_o, e.pl);
`ifdef T09_TONE_DONE_PULSE_EN
        chk({e.name, " done"}, e.cyc, done_w, e.dn);
`endif
      end
    end
    if (idx != tbl.size()) begin
      errors++;
      $display("FAIL %s table: applied %0d required %0d", name, idx, tbl.size());
    end
    tbl.delete();
  endtask

  initial begin
    freq_i = 8'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("reset square", 0, square_o, 1'b0);
    chk("reset playing", 0, playing_o, 1'b0);
    chk("reset done", 0, done_w, 1'b0);

    tbl = '{'{0,3,0,1,0}, '{1,0,0,1,0}, '{11,0,0,1,0}, '{12,0,1,1,0}, '{23,0,1,1,0},
            '{24,0,0,1,0}, '{31,0,0,1,0}, '{32,0,0,0,1}, '{33,0,0,0,0}, '{34,0,0,0,0}};
    run("single", 35);

    tbl = '{'{0,2,0,1,0}, '{8,2,1,1,0}, '{16,2,0,1,0}, '{24,2,1,1,0}, '{31,2,1,1,0},
            '{32,2,0,0,1}, '{33,2,0,0,0}, '{60,2,0,0,0}, '{99,2,0,0,0}, '{100,0,0,0,0},
            '{101,2,0,1,0}, '{109,2,1,1,0}, '{133,2,0,0,1}};
    run("held", 134);

    tbl = '{'{0,5,0,1,0}, '{9,5,0,1,0}, '{10,2,0,1,0}, '{17,2,0,1,0}, '{18,2,1,1,0},
            '{20,2,1,1,0}, '{26,2,0,1,0}, '{34,2,1,1,0}, '{41,2,1,1,0}, '{42,2,0,0,1},
            '{43,0,0,0,0}};
    run("retrigger", 44);

    tbl = '{'{0,4,0,1,0}, '{1,0,0,1,0}, '{16,0,1,1,0}, '{31,0,1,1,0}, '{32,6,0,1,0},
            '{33,0,0,1,0}, '{55,0,0,1,0}, '{56,0,1,1,0}, '{63,0,1,1,0}, '{64,0,0,0,1},
            '{65,0,0,0,0}};
    run("same_edge", 66);

    tbl = '{'{0,1,0,1,0}, '{1,0,0,1,0}, '{4,0,1,1,0}, '{5,0,1,1,0}};
    run("async_pre", 6);
    #3 nrst = 1'b0;
    #1;
    chk("async square", 6, square_o, 1'b0);
    chk("async playing", 6, playing_o, 1'b0);
    nrst = 1'b1;
    freq_i = 8'd0;
    @(posedge clk);
    #1;
    chk("async idle", 7, playing_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
